// File: rtl/enc_pkg.sv
// Shared defaults, derived-size helpers and state type for the encoder slice sequencer.
package enc_pkg;

  localparam int HV_DIM_DEFAULT      = 5000;
  localparam int DIMS_PER_CC_DEFAULT = 500;

  // Ceil divide; a zero slice width is rejected at elaboration by the top.
  function automatic int calc_num_slices(input int hv_dim, input int dims_per_cc);
    if (dims_per_cc < 1) return 1;
    return (hv_dim + dims_per_cc - 1) / dims_per_cc;
  endfunction

  function automatic int calc_idx_w(input int num_slices);
    if (num_slices <= 1) return 1;
    return $clog2(num_slices);
  endfunction

  typedef enum logic {
    IDLE,
    STREAM
  } enc_seq_state_t;

endpackage

// File: rtl/enc_slice_mux.sv
// Selects slice idx of a held hypervector; bits beyond HV_DIM in the last slice read as zero.
module enc_slice_mux
  import enc_pkg::*;
#(
  parameter int  HV_DIM      = HV_DIM_DEFAULT,
  parameter int  DIMS_PER_CC = DIMS_PER_CC_DEFAULT,
  localparam int NUM_SLICES  = calc_num_slices(HV_DIM, DIMS_PER_CC),
  localparam int IDX_W       = calc_idx_w(NUM_SLICES)
) (
  input  logic [HV_DIM-1:0]      hv_reg,
  input  logic [IDX_W-1:0]       idx,
  input  logic                   en,
  output logic [DIMS_PER_CC-1:0] slice
);

  localparam int PAD_W = NUM_SLICES * DIMS_PER_CC;

  // Zero-extending to a whole number of slices makes the remainder padding free.
  logic [PAD_W-1:0] padded;
  assign padded = PAD_W'(hv_reg);

  always_comb begin
    slice = '0;
    if (en && (int'(idx) < NUM_SLICES)) begin
      slice = padded[int'(idx)*DIMS_PER_CC +: DIMS_PER_CC];
    end
  end

endmodule

// File: rtl/enc_slice_sequencer.sv
// Captures one hypervector and streams it out as DIMS_PER_CC-bit slices over valid/ready.
//
// state  | meaning
// IDLE   | no vector held, in_ready high, out_valid low
// STREAM | vector held, slice idx presented on out_data
module enc_slice_sequencer
  import enc_pkg::*;
#(
  parameter int  HV_DIM      = HV_DIM_DEFAULT,
  parameter int  DIMS_PER_CC = DIMS_PER_CC_DEFAULT,
  localparam int NUM_SLICES  = calc_num_slices(HV_DIM, DIMS_PER_CC),
  localparam int IDX_W       = calc_idx_w(NUM_SLICES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [HV_DIM-1:0]      hv_in,
  input  logic                   abort,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIMS_PER_CC-1:0] out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   busy
);

  if (DIMS_PER_CC < 1 || DIMS_PER_CC > HV_DIM) begin : g_bad_params
    $error("enc_slice_sequencer: DIMS_PER_CC must be in 1..HV_DIM");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  enc_seq_state_t    state;
  logic [HV_DIM-1:0] hv_reg;
  logic [IDX_W-1:0]  idx;

  logic streaming;
  logic beat_done;
  logic accept;

  assign streaming = (state == STREAM);
  assign beat_done = streaming & out_ready;

  assign out_valid = streaming;
  assign busy      = streaming;
  assign out_idx   = idx;
  assign out_last  = streaming & (idx == LAST_IDX);

  // Reload is offered on the final handshake so back-to-back vectors stream without a bubble.
  assign in_ready  = ~streaming | (beat_done & out_last & ~abort);
  assign accept    = in_valid & in_ready & ~abort;

  enc_slice_mux #(
    .HV_DIM      (HV_DIM),
    .DIMS_PER_CC (DIMS_PER_CC)
  ) u_slice_mux (
    .hv_reg (hv_reg),
    .idx    (idx),
    .en     (streaming),
    .slice  (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hv_reg <= '0;
      idx    <= '0;
    end else if (abort) begin
      // hv_reg is deliberately kept; only the stream position is dropped.
      state <= IDLE;
      idx   <= '0;
    end else if (accept) begin
      hv_reg <= hv_in;
      idx    <= '0;
      state  <= STREAM;
    end else if (beat_done) begin
      if (out_last) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: doc/enc_slice_sequencer.md
Name: enc_slice_sequencer

Overview:
Parametrised, sequential successor to the fixed 10-way encoder input mux. It captures one HV_DIM-bit hypervector and streams it out as consecutive DIMS_PER_CC-bit slices, one slice per accepted beat. Both sides use valid/ready handshakes, so the stream supports backpressure. A non-divisible final slice is zero-padded. The block sits between the bundling stage and the per-cycle encoder datapath.

Parameters:
- HV_DIM, 5000, hypervector width in bits.
- DIMS_PER_CC, 500, slice width in bits emitted per beat. Must satisfy 1 <= DIMS_PER_CC <= HV_DIM; any other value is an elaboration error.
- NUM_SLICES, ceil(HV_DIM/DIMS_PER_CC), derived, not overridable.
- IDX_W, max(1, $clog2(NUM_SLICES)), derived slice-index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  hv_in is valid.
- in_ready  output  1  block can accept a new hypervector.
- hv_in  input  HV_DIM  hypervector to be sliced.
- abort  input  1  synchronous abandon of the current vector.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the current slice.
- out_data  output  DIMS_PER_CC  current slice.
- out_idx  output  IDX_W  index of the current slice.
- out_last  output  1  current slice is slice NUM_SLICES-1.
- busy  output  1  a vector is held (state STREAM).

Behaviour:
- FSM states: IDLE, STREAM. State, hv_reg and idx are reset asynchronously on rst_n low.
- Reset values: state=IDLE, hv_reg=0, idx=0, out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0. in_ready=1 while rst_n is high and state is IDLE.
- in_ready is high when state is IDLE, or in STREAM when out_valid & out_ready & out_last & !abort (zero-bubble reload).
- Accept (in_valid & in_ready): hv_reg<=hv_in, idx<=0, state<=STREAM. Slice 0 appears on out_valid the next cycle, so latency is 1 cycle.
- In STREAM:
  - out_valid=1.
  - out_idx=idx.
  - out_last=(idx==NUM_SLICES-1).
  - out_data[j] = hv_reg[idx*DIMS_PER_CC + j] when that bit index < HV_DIM, else 0.
- out_data, out_idx and out_last are combinational from registered state only; there is no combinational path from in_* or out_ready to out_data.
- Handshake rules:
  - While out_valid & !out_ready, all outputs hold stable.
  - On out_valid & out_ready & !out_last: idx<=idx+1.
  - On out_valid & out_ready & out_last: without a simultaneous accept, state<=IDLE and idx<=0; with a simultaneous accept, the reload takes effect (STREAM, idx=0, new hv_reg).
- idx never exceeds NUM_SLICES-1. There is no wrap except via last-slice completion.
- abort has highest priority after reset:
  - Next cycle: state=IDLE, idx=0, out_valid=0. hv_reg is not cleared.
  - in_ready is low in the abort cycle if state is STREAM. A beat handshaken in the same cycle as abort counts as delivered, but no further slices are emitted.
  - abort in IDLE has no effect, and an accept in the same cycle is blocked.
- out_data=0 whenever out_valid=0.
- rst_n asserted mid-stream: all state clears immediately and asynchronously; the in-flight vector is lost.
- NUM_SLICES=1 (DIMS_PER_CC=HV_DIM): out_last=1 on every beat.

Decomposition:
- Package enc_pkg holds:
  - HV_DIM and DIMS_PER_CC defaults.
  - A NUM_SLICES function (ceil divide).
  - An IDX_W function.
  - typedef enum logic {IDLE, STREAM} enc_seq_state_t.
- One sub-module, enc_slice_mux. It is purely combinational, parametrised by HV_DIM/DIMS_PER_CC, and maps hv_reg and idx to a zero-padded out_data. It is the generalised replacement for the hard-coded 10-way case mux.
- The FSM, index counter and handshake logic live in enc_slice_sequencer.

Test Plan:
- Default params (5000/500), hv_in[i]=(i%7==0), out_ready=1 → 10 beats on consecutive cycles starting 1 cycle after accept; beat k equals hv_in[500k+499:500k]; out_last only on idx 9; in_ready high the cycle after.
- Backpressure: out_ready=0 for 3 cycles at idx 4 → out_data/out_idx/out_last are stable; idx 5 follows the first cycle with out_ready=1; total 10 handshakes with no duplicates.
- Remainder (HV_DIM=1000, DIMS_PER_CC=300), hv_in all ones → 4 beats; beat 3 has out_data[99:0]=all ones, [299:100]=0, and out_last=1.
- Back-to-back: in_valid held high with vectors A then B, out_ready=1 → B is accepted in the same cycle as A's last beat; B's slice 0 appears the next cycle; 20 contiguous beats with no bubble.
- Abort at idx 3 with out_ready=1 → out_valid=0 and in_ready=1 the next cycle; a following accept restarts at out_idx=0 with the new data.
- rst_n low for 1 cycle during idx 6 → outputs go to reset values asynchronously; after release in_ready=1, busy=0, and no stale beats appear.
